// File: rtl/wbq_pkg.sv
// rtl/wbq_pkg.sv - shared widths and entry type for the writeback queue
package wbq_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// rtl/wbq_fwd_match.sv - youngest-match search over pending writeback entries
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wbq_entry_t            entries [DEPTH],
    input  logic [PTR_W-1:0]      head,
    input  logic [CNT_W-1:0]      count,
    input  logic [REG_ADDR_W-1:0] rs,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [PTR_W-1:0] slot;

    // Walk pending entries oldest to youngest so the last match seen is the youngest
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[slot].rd == rs)) begin
                hit  = 1'b1;
                data = entries[slot].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback queue with optional forwarding (WB_QUEUE_FWD_EN)
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  drain_en,
    output logic                  write,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     Dc,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [DATA_W-1:0]     fwd_a_data,
    output logic [DATA_W-1:0]     fwd_b_data,
    output logic [CNT_W-1:0]      count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wbq_entry_t       mem_q [DEPTH];
    wbq_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Head presentation and handshake; the register file accepts every write
    always_comb begin
        in_ready = (count_q < DEPTH_C);
        write    = (count_q != '0) && drain_en;
        rd       = '0;
        Dc       = '0;
        if (count_q != '0) begin
            rd = mem_q[head_q].rd;
            Dc = mem_q[head_q].data;
        end
        push = in_valid && in_ready;
        pop  = write;
    end

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = '{rd: in_rd, data: in_data};
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards pending entries
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; validity comes from head and count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;

`ifdef WB_QUEUE_FWD_EN
    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .rs      (rs1),
        .hit     (fwd_a_hit),
        .data    (fwd_a_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .rs      (rs2),
        .hit     (fwd_b_hit),
        .data    (fwd_b_data)
    );
`else
    logic unused_rs;
    assign unused_rs  = ^{rs1, rs2};
    assign fwd_a_hit  = 1'b0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue
module tb_wb_queue;

`ifdef WB_QUEUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, drain_en;
    logic [4:0]  in_rd, rs1, rs2, rd;
    logic [31:0] in_data, Dc, fwd_a_data, fwd_b_data;
    logic        in_ready, write, fwd_a_hit, fwd_b_hit;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .drain_en   (drain_en),
        .write      (write),
        .rd         (rd),
        .Dc         (Dc),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
        .count      (count)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] idata;
        logic        de;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ready;
        logic        e_write;
        logic [4:0]  e_rd;
        logic [31:0] e_dc;
        logic [2:0]  e_cnt;
        logic        e_fah;
        logic [31:0] e_fad;
        logic        e_fbh;
        logic [31:0] e_fbd;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic rst_i, logic iv_i, logic [4:0] ird_i, logic [31:0] idata_i,
                                logic de_i, logic [4:0] r1_i, logic [4:0] r2_i,
                                logic rdy, logic wr, logic [4:0] erd, logic [31:0] edc,
                                logic [2:0] ecnt, logic fah, logic [31:0] fad,
                                logic fbh, logic [31:0] fbd);
        vec_t v;
        v.rst = rst_i; v.iv = iv_i; v.ird = ird_i; v.idata = idata_i;
        v.de = de_i; v.r1 = r1_i; v.r2 = r2_i;
        v.e_ready = rdy; v.e_write = wr; v.e_rd = erd; v.e_dc = edc; v.e_cnt = ecnt;
        v.e_fah = fah & FWD;
        v.e_fad = fad & {32{FWD}};
        v.e_fbh = fbh & FWD;
        v.e_fbd = fbd & {32{FWD}};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [4:0] ird,
                         input logic [31:0] idata, input logic de,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        reset = r; in_valid = iv; in_rd = ird; in_data = idata;
        drain_en = de; rs1 = r1; rs2 = r2;
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_ready));
        chk({tag, ".write"}, 32'(write), 32'(v.e_write));
        chk({tag, ".rd"}, 32'(rd), 32'(v.e_rd));
        chk({tag, ".Dc"}, Dc, v.e_dc);
        chk({tag, ".count"}, 32'(count), 32'(v.e_cnt));
        chk({tag, ".fwd_a_hit"}, 32'(fwd_a_hit), 32'(v.e_fah));
        chk({tag, ".fwd_a_data"}, fwd_a_data, v.e_fad);
        chk({tag, ".fwd_b_hit"}, 32'(fwd_b_hit), 32'(v.e_fbh));
        chk({tag, ".fwd_b_data"}, fwd_b_data, v.e_fbd);
    endtask

    initial begin
        int pushed;
        int popped;
        vec_t zero_v;

        //            rst iv ird  idata         de r1 r2  rdy wr rd  Dc            cnt fah fad           fbh fbd
        tbl[0]  = mk(0, 1, 3,  32'hDEADBEEF, 1, 3, 0,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(0, 0, 0,  32'h0,        1, 3, 3,  1, 1, 3,  32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        tbl[2]  = mk(0, 0, 0,  32'h0,        1, 3, 3,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[3]  = mk(0, 1, 0,  32'h5A,       0, 0, 0,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[4]  = mk(0, 0, 0,  32'h0,        0, 0, 9,  1, 0, 0,  32'h5A,       1, 1, 32'h5A,       0, 32'h0);
        tbl[5]  = mk(0, 0, 0,  32'h0,        1, 0, 9,  1, 1, 0,  32'h5A,       1, 1, 32'h5A,       0, 32'h0);
        tbl[6]  = mk(0, 1, 7,  32'h11,       0, 7, 8,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[7]  = mk(0, 1, 7,  32'h22,       0, 7, 8,  1, 0, 7,  32'h11,       1, 1, 32'h11,       0, 32'h0);
        tbl[8]  = mk(0, 0, 0,  32'h0,        0, 7, 8,  1, 0, 7,  32'h11,       2, 1, 32'h22,       0, 32'h0);
        tbl[9]  = mk(0, 0, 0,  32'h0,        1, 7, 8,  1, 1, 7,  32'h11,       2, 1, 32'h22,       0, 32'h0);
        tbl[10] = mk(0, 0, 0,  32'h0,        1, 7, 8,  1, 1, 7,  32'h22,       1, 1, 32'h22,       0, 32'h0);
        tbl[11] = mk(0, 0, 0,  32'h0,        1, 7, 8,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[12] = mk(0, 1, 1,  32'h101,      0, 1, 2,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[13] = mk(0, 1, 2,  32'h102,      0, 1, 2,  1, 0, 1,  32'h101,      1, 1, 32'h101,      0, 32'h0);
        tbl[14] = mk(0, 1, 3,  32'h103,      0, 1, 2,  1, 0, 1,  32'h101,      2, 1, 32'h101,      1, 32'h102);
        tbl[15] = mk(1, 1, 4,  32'h104,      1, 3, 2,  1, 1, 1,  32'h101,      3, 1, 32'h103,      1, 32'h102);
        tbl[16] = mk(0, 0, 0,  32'h0,        1, 3, 4,  1, 0, 0,  32'h0,        0, 0, 32'h0,        0, 32'h0);

        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        drain_en = 1'b0; rs1 = '0; rs2 = '0;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_all("reset", zero_v);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ird, tbl[i].idata, tbl[i].de, tbl[i].r1, tbl[i].r2);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Fill with drain held off; fifth offer is refused and not visible to forwarding
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 5'(10 + i), 32'hA0 + 32'(i), 0, 5'(10 + i), 0);
            chk($sformatf("fill%0d.in_ready", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i < 4 ? i : 4));
        end
        chk("full.fwd_a_hit_5th", 32'(fwd_a_hit), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk($sformatf("drain%0d.write", i), 32'(write), 32'd1);
            chk($sformatf("drain%0d.rd", i), 32'(rd), 32'(10 + i));
            chk($sformatf("drain%0d.Dc", i), Dc, 32'hA0 + 32'(i));
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("drained.write", 32'(write), 32'd0);
        chk("drained.count", 32'(count), 32'd0);

        // Streaming through a full queue with pointer wrap: 20 pushes, 20 in-order writes
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'(i), 32'h1000 + 32'(i), 0, 0, 0);
        end
        pushed = 4;
        popped = 0;
        for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
            drive(0, pushed < 20, 5'(pushed), 32'h1000 + 32'(pushed), 1, 0, 0);
            if (cyc == 0) chk("stream.count_full", 32'(count), 32'd4);
            if (cyc == 1) chk("stream.count_after_pop", 32'(count), 32'd3);
            if (write) begin
                chk($sformatf("stream%0d.rd", popped), 32'(rd), 32'(popped % 32));
                chk($sformatf("stream%0d.Dc", popped), Dc, 32'h1000 + 32'(popped));
                popped++;
            end
            if (in_valid && in_ready) pushed++;
        end
        chk("stream.total_writes", 32'(popped), 32'd20);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("stream.end_count", 32'(count), 32'd0);
        chk("stream.end_write", 32'(write), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
